// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Signed or unsigned per operation, start/done handshake, busy and
// divide-by-zero status. Quotient, remainder and flag are held until the
// next accepted start.
// Optional build macro SEQ_DIV_ZERO_FAST_EN: a zero divisor at start skips
// the iteration and goes straight to DONE. Result values are the same
// either way; only the latency differs.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;            // partial remainder (magnitude)
  logic [WIDTH-1:0] r_quo;            // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dvs;            // divisor magnitude
  logic [WIDTH-1:0] r_dividend_raw;   // untouched dividend for the zero-divisor result
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  // Operand conditioning at start
  logic             w_zero_in;
  logic             w_neg_dividend;
  logic             w_neg_divisor;
  logic [WIDTH-1:0] w_abs_dividend;
  logic [WIDTH-1:0] w_abs_divisor;
  logic             w_fast_zero;

  assign w_zero_in      = (divisor == '0);
  assign w_neg_dividend = is_signed & dividend[WIDTH-1];
  assign w_neg_divisor  = is_signed & divisor[WIDTH-1];
  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits as unsigned.
  assign w_abs_dividend = w_neg_dividend ? -dividend : dividend;
  assign w_abs_divisor  = w_neg_divisor  ? -divisor  : divisor;

`ifdef SEQ_DIV_ZERO_FAST_EN
  assign w_fast_zero = w_zero_in;
`else
  assign w_fast_zero = 1'b0;
`endif

  // One restoring step. The shifted remainder needs one extra bit; since the
  // remainder is always below the divisor, the difference fits in WIDTH bits
  // when non-negative, so the top bit of the trial is a clean borrow.
  logic [WIDTH:0] w_rem_shift;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_dvs};
  assign w_fits      = ~w_trial[WIDTH];

  // Sign correction and zero-divisor override applied in FIX
  logic [WIDTH-1:0] w_fix_quotient;
  logic [WIDTH-1:0] w_fix_remainder;

  assign w_fix_quotient  = r_zero ? '1 : (r_sign_q ? -r_quo : r_quo);
  assign w_fix_remainder = r_zero ? r_dividend_raw : (r_sign_r ? -r_rem : r_rem);

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next_state = w_fast_zero ? S_DONE : S_CALC;
      S_CALC: if (r_count == CNT_ONE) w_next_state = S_FIX;
      S_FIX:  w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    if (r_state == S_DONE) done = 1'b1;
    if (r_state != S_IDLE) busy = 1'b1;
  end

  // Datapath: operand capture, iteration, result registration
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: every datapath register is reset so an aborted operation leaves
    // no stale operand or sign state behind.
    if (clr) begin
      r_count        <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_dvs          <= '0;
      r_dividend_raw <= '0;
      r_sign_q       <= 1'b0;
      r_sign_r       <= 1'b0;
      r_zero         <= 1'b0;
      r_quotient     <= '0;
      r_remainder    <= '0;
      r_div_by_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem          <= '0;
            r_quo          <= w_abs_dividend;
            r_dvs          <= w_abs_divisor;
            r_dividend_raw <= dividend;
            r_sign_q       <= w_neg_dividend ^ w_neg_divisor;
            r_sign_r       <= w_neg_dividend;
            r_zero         <= w_zero_in;
            if (w_fast_zero) begin
              r_count       <= '0;
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_count       <= CNT_INIT;
              r_div_by_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_fits ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_fits};
          r_count <= r_count - CNT_ONE;
        end
        S_FIX: begin
          r_quotient    <= w_fix_quotient;
          r_remainder   <= w_fix_remainder;
          r_div_by_zero <= r_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
